// File: rtl/sm83_pkg.sv
// Shared types for the SM83 flags-register sequencer.
// SM83_FLAGS_SEQ_DAA_EN adds the two-cycle DAA states to the state enum.
package sm83_pkg;

    typedef enum logic [3:0] {
        OP_NOP      = 4'd0,
        OP_ALU8     = 4'd1,
        OP_INC_DEC  = 4'd2,
        OP_ADD16    = 4'd3,
        OP_ADD_SP   = 4'd4,
        OP_ROT_A    = 4'd5,
        OP_CB_SHIFT = 4'd6,
        OP_BIT      = 4'd7,
        OP_DAA      = 4'd8,
        OP_CPL      = 4'd9,
        OP_SCF      = 4'd10,
        OP_CCF      = 4'd11,
        OP_POP_AF   = 4'd12
    } flag_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_LO,
        ST_HI
`ifdef SM83_FLAGS_SEQ_DAA_EN
        ,
        ST_DAA1,
        ST_DAA2
`endif
    } flags_seq_state_e;

    typedef struct packed {
        logic flags_bus;
        logic flags_alu;
        logic zero_we;
        logic zero_clr;
        logic half_carry_we;
        logic half_carry_set;
        logic half_carry_cpl;
        logic daa_carry_we;
        logic neg_we;
        logic neg_set;
        logic neg_clr;
        logic carry_we;
        logic sec_carry_we;
        logic sec_carry_sh;
        logic sec_carry_daa;
        logic sec_carry_sel;
        logic carry_set;
        logic carry_cpl;
        logic alu_hi;
    } flags_ctl_t;

endpackage

// File: rtl/sm83_flags_decode.sv
// Combinational strobe map from (state, latched op, subtract variant).
// SM83_FLAGS_SEQ_DAA_EN compiles the DAA1/DAA2 strobe sets.
module sm83_flags_decode
    import sm83_pkg::*;
(
    input  flags_seq_state_e state,
    input  flag_op_e         op,
    input  logic             op_sub,
    output flags_ctl_t       ctl
);

    always_comb begin
        // NOTE: default every field first so no path through the case infers a latch.
        ctl = '0;
        case (state)
            ST_EXEC: begin
                case (op)
                    OP_ALU8, OP_INC_DEC: begin
                        ctl.flags_alu     = 1'b1;
                        ctl.zero_we       = 1'b1;
                        ctl.half_carry_we = 1'b1;
                        ctl.daa_carry_we  = 1'b1;
                        ctl.neg_we        = 1'b1;
                        ctl.neg_set       = op_sub;
                        ctl.neg_clr       = !op_sub;
                        ctl.carry_we      = (op == OP_ALU8);
                    end
                    OP_ROT_A, OP_CB_SHIFT: begin
                        ctl.flags_alu      = 1'b1;
                        ctl.sec_carry_we   = 1'b1;
                        ctl.sec_carry_sh   = 1'b1;
                        ctl.sec_carry_sel  = 1'b1;
                        ctl.zero_we        = 1'b1;
                        ctl.zero_clr       = (op == OP_ROT_A);
                        ctl.half_carry_we  = 1'b1;
                        ctl.half_carry_set = 1'b1;
                        ctl.half_carry_cpl = 1'b1;
                        ctl.neg_we         = 1'b1;
                        ctl.neg_clr        = 1'b1;
                    end
                    OP_BIT: begin
                        ctl.flags_alu      = 1'b1;
                        ctl.zero_we        = 1'b1;
                        ctl.half_carry_we  = 1'b1;
                        ctl.half_carry_set = 1'b1;
                        ctl.neg_we         = 1'b1;
                        ctl.neg_clr        = 1'b1;
                    end
                    OP_CPL: begin
                        ctl.flags_alu      = 1'b1;
                        ctl.half_carry_we  = 1'b1;
                        ctl.half_carry_set = 1'b1;
                        ctl.neg_we         = 1'b1;
                        ctl.neg_set        = 1'b1;
                    end
                    OP_SCF, OP_CCF: begin
                        ctl.flags_alu     = 1'b1;
                        ctl.carry_we      = 1'b1;
                        ctl.carry_set     = (op == OP_SCF);
                        ctl.carry_cpl     = (op == OP_CCF);
                        ctl.half_carry_we = 1'b1;
                        ctl.neg_we        = 1'b1;
                        ctl.neg_clr       = 1'b1;
                    end
                    OP_POP_AF: begin
                        ctl.flags_bus     = 1'b1;
                        ctl.zero_we       = 1'b1;
                        ctl.neg_we        = 1'b1;
                        ctl.half_carry_we = 1'b1;
                        ctl.carry_we      = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_LO: begin
                ctl.flags_alu     = 1'b1;
                ctl.sec_carry_we  = 1'b1;
                ctl.sec_carry_sel = 1'b1;
            end
            ST_HI: begin
                ctl.flags_alu     = 1'b1;
                ctl.alu_hi        = 1'b1;
                ctl.sec_carry_sel = 1'b1;
                ctl.half_carry_we = 1'b1;
                ctl.carry_we      = 1'b1;
                ctl.neg_we        = 1'b1;
                ctl.neg_clr       = 1'b1;
                ctl.zero_we       = (op == OP_ADD_SP);
                ctl.zero_clr      = (op == OP_ADD_SP);
            end
`ifdef SM83_FLAGS_SEQ_DAA_EN
            ST_DAA1: begin
                ctl.flags_alu     = 1'b1;
                ctl.sec_carry_we  = 1'b1;
                ctl.sec_carry_daa = 1'b1;
            end
            ST_DAA2: begin
                ctl.flags_alu     = 1'b1;
                ctl.sec_carry_sel = 1'b1;
                ctl.zero_we       = 1'b1;
                ctl.half_carry_we = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/sm83_flags_seq.sv
// Flags-register strobe sequencer: one flag-op per handshake, Moore strobes.
// SM83_FLAGS_SEQ_DAA_EN enables the two-cycle DAA sequence; otherwise DAA acts as NOP.
module sm83_flags_seq
    import sm83_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [3:0] op_kind,
    input  logic       op_sub,
    input  logic       flush,
    output logic       busy,
    output logic       done,
    output logic       alu_hi,
    output logic       flags_bus,
    output logic       flags_alu,
    output logic       zero_we,
    output logic       zero_clr,
    output logic       half_carry_we,
    output logic       half_carry_set,
    output logic       half_carry_cpl,
    output logic       daa_carry_we,
    output logic       neg_we,
    output logic       neg_set,
    output logic       neg_clr,
    output logic       carry_we,
    output logic       sec_carry_we,
    output logic       sec_carry_sh,
    output logic       sec_carry_daa,
    output logic       sec_carry_sel,
    output logic       carry_set,
    output logic       carry_cpl
);

    flags_seq_state_e state_q, state_d;
    flag_op_e         op_q;
    logic             sub_q;
    logic             accept;
    flags_ctl_t       dec_ctl, ctl;

    assign op_ready = (state_q == ST_IDLE);
    assign busy     = !op_ready;
    assign accept   = op_valid && op_ready && !flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q  <= OP_NOP;
            sub_q <= 1'b0;
        end else if (accept) begin
            op_q  <= flag_op_e'(op_kind);
            sub_q <= op_sub;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    case (op_kind)
                        OP_ADD16, OP_ADD_SP: state_d = ST_LO;
`ifdef SM83_FLAGS_SEQ_DAA_EN
                        OP_DAA:              state_d = ST_DAA1;
`endif
                        default:             state_d = ST_EXEC;
                    endcase
                end
                ST_LO:   state_d = ST_HI;
`ifdef SM83_FLAGS_SEQ_DAA_EN
                ST_DAA1: state_d = ST_DAA2;
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    sm83_flags_decode u_decode (
        .state  (state_q),
        .op     (op_q),
        .op_sub (sub_q),
        .ctl    (dec_ctl)
    );

    // Flush silences the whole cycle, including the completion pulse.
    always_comb begin
        ctl  = flush ? '0 : dec_ctl;
        done = 1'b0;
        if (!flush) begin
            case (state_q)
                ST_EXEC, ST_HI: done = 1'b1;
`ifdef SM83_FLAGS_SEQ_DAA_EN
                ST_DAA2:        done = 1'b1;
`endif
                default:        done = 1'b0;
            endcase
        end
    end

    assign alu_hi         = ctl.alu_hi;
    assign flags_bus      = ctl.flags_bus;
    assign flags_alu      = ctl.flags_alu;
    assign zero_we        = ctl.zero_we;
    assign zero_clr       = ctl.zero_clr;
    assign half_carry_we  = ctl.half_carry_we;
    assign half_carry_set = ctl.half_carry_set;
    assign half_carry_cpl = ctl.half_carry_cpl;
    assign daa_carry_we   = ctl.daa_carry_we;
    assign neg_we         = ctl.neg_we;
    assign neg_set        = ctl.neg_set;
    assign neg_clr        = ctl.neg_clr;
    assign carry_we       = ctl.carry_we;
    assign sec_carry_we   = ctl.sec_carry_we;
    assign sec_carry_sh   = ctl.sec_carry_sh;
    assign sec_carry_sel  = ctl.sec_carry_sel;
    assign carry_set      = ctl.carry_set;
    assign carry_cpl      = ctl.carry_cpl;
`ifdef SM83_FLAGS_SEQ_DAA_EN
    assign sec_carry_daa  = ctl.sec_carry_daa;
`else
    assign sec_carry_daa  = 1'b0;
`endif

endmodule

// File: tb/tb_sm83_flags_seq.sv
// Directed and random-stream bench for sm83_flags_seq (DAA expectations follow SM83_FLAGS_SEQ_DAA_EN).
module tb_sm83_flags_seq;

    localparam logic [3:0] K_NOP = 4'd0, K_ALU8 = 4'd1, K_INC_DEC = 4'd2, K_ADD16 = 4'd3,
                           K_ADD_SP = 4'd4, K_ROT_A = 4'd5, K_CB_SHIFT = 4'd6, K_BIT = 4'd7,
                           K_DAA = 4'd8, K_CPL = 4'd9, K_SCF = 4'd10, K_CCF = 4'd11,
                           K_POP_AF = 4'd12;

    localparam logic [21:0] V_BUS   = 22'd1 << 21, V_ALU   = 22'd1 << 20, V_ZWE   = 22'd1 << 19,
                            V_ZCLR  = 22'd1 << 18, V_HWE   = 22'd1 << 17, V_HSET  = 22'd1 << 16,
                            V_HCPL  = 22'd1 << 15, V_DCWE  = 22'd1 << 14, V_NWE   = 22'd1 << 13,
                            V_NSET  = 22'd1 << 12, V_NCLR  = 22'd1 << 11, V_CWE   = 22'd1 << 10,
                            V_SCWE  = 22'd1 << 9,  V_SCSH  = 22'd1 << 8,  V_SCDAA = 22'd1 << 7,
                            V_SCSEL = 22'd1 << 6,  V_CSET  = 22'd1 << 5,  V_CCPL  = 22'd1 << 4,
                            V_AHI   = 22'd1 << 3,  V_DONE  = 22'd1 << 2,  V_BUSY  = 22'd1 << 1,
                            V_RDY   = 22'd1 << 0;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic op_valid = 1'b0, op_sub = 1'b0, flush = 1'b0;
    logic [3:0] op_kind = 4'd0;
    logic op_ready, busy, done, alu_hi, flags_bus, flags_alu, zero_we, zero_clr;
    logic half_carry_we, half_carry_set, half_carry_cpl, daa_carry_we, neg_we, neg_set, neg_clr;
    logic carry_we, sec_carry_we, sec_carry_sh, sec_carry_daa, sec_carry_sel, carry_set, carry_cpl;

    int n_cmp = 0;
    int n_bad = 0;
    logic [21:0] obs;

    always #5 clk = ~clk;

    sm83_flags_seq dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_kind(op_kind), .op_sub(op_sub), .flush(flush), .busy(busy), .done(done),
        .alu_hi(alu_hi), .flags_bus(flags_bus), .flags_alu(flags_alu), .zero_we(zero_we),
        .zero_clr(zero_clr), .half_carry_we(half_carry_we), .half_carry_set(half_carry_set),
        .half_carry_cpl(half_carry_cpl), .daa_carry_we(daa_carry_we), .neg_we(neg_we),
        .neg_set(neg_set), .neg_clr(neg_clr), .carry_we(carry_we), .sec_carry_we(sec_carry_we),
        .sec_carry_sh(sec_carry_sh), .sec_carry_daa(sec_carry_daa), .sec_carry_sel(sec_carry_sel),
        .carry_set(carry_set), .carry_cpl(carry_cpl)
    );

    assign obs = {flags_bus, flags_alu, zero_we, zero_clr, half_carry_we, half_carry_set,
                  half_carry_cpl, daa_carry_we, neg_we, neg_set, neg_clr, carry_we,
                  sec_carry_we, sec_carry_sh, sec_carry_daa, sec_carry_sel, carry_set,
                  carry_cpl, alu_hi, done, busy, op_ready};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Present one request on the falling edge; after the accept edge scramble the inputs
    // so a design that fails to latch the op shows it, then stop at the first strobe cycle.
    task automatic issue(input string tag, input logic [3:0] k, input logic s);
        @(negedge clk);
        check({tag, "_rdy"}, 32'(op_ready), 32'd1);
        op_valid = 1'b1;
        op_kind  = k;
        op_sub   = s;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_kind  = 4'hF;
        op_sub   = ~s;
        @(negedge clk);
    endtask

    task automatic run1(input string tag, input logic [3:0] k, input logic s, input logic [21:0] e1);
        issue(tag, k, s);
        check({tag, "_c1"}, 32'(obs), 32'(e1 | V_DONE | V_BUSY));
        @(negedge clk);
        check({tag, "_idle"}, 32'(obs), 32'(V_RDY));
    endtask

    task automatic run2(input string tag, input logic [3:0] k, input logic s,
                        input logic [21:0] e1, input logic [21:0] e2);
        issue(tag, k, s);
        check({tag, "_c1"}, 32'(obs), 32'(e1 | V_BUSY));
        @(negedge clk);
        check({tag, "_c2"}, 32'(obs), 32'(e2 | V_DONE | V_BUSY));
        @(negedge clk);
        check({tag, "_idle"}, 32'(obs), 32'(V_RDY));
    endtask

    // Legality rules of the flags register, watched on every falling edge.
    always @(negedge clk) begin
        logic any_we;
        any_we = zero_we | half_carry_we | daa_carry_we | neg_we | carry_we | sec_carry_we;
        check("inv_carry_excl", 32'(carry_we & sec_carry_we), 32'd0);
        check("inv_src", 32'(2'(flags_bus) + 2'(flags_alu)), 32'(any_we));
        check("inv_sec_src", 32'(sec_carry_sh & sec_carry_daa), 32'd0);
        if (op_ready) check("inv_idle_quiet", 32'(obs[21:3]), 32'd0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        localparam logic [21:0] ALU8_BASE = V_ALU | V_ZWE | V_HWE | V_DCWE | V_NWE;
        localparam logic [21:0] ROT_SET   = V_SCWE | V_SCSH | V_SCSEL | V_ZWE | V_HWE |
                                            V_HSET | V_HCPL | V_NWE | V_NCLR | V_ALU;
        localparam logic [21:0] LO_SET    = V_SCWE | V_SCSEL | V_ALU;
        localparam logic [21:0] HI_SET    = V_AHI | V_SCSEL | V_HWE | V_CWE | V_NWE | V_NCLR | V_ALU;

        #12;
        check("reset_state", 32'(obs), 32'(V_RDY));
        reset_n = 1'b1;

        run1("alu8_sub", K_ALU8, 1'b1, ALU8_BASE | V_NSET | V_CWE);
        run1("alu8_add", K_ALU8, 1'b0, ALU8_BASE | V_NCLR | V_CWE);
        run1("incdec_dec", K_INC_DEC, 1'b1, ALU8_BASE | V_NSET);
        run1("incdec_inc", K_INC_DEC, 1'b0, ALU8_BASE | V_NCLR);
        run1("rot_a", K_ROT_A, 1'b1, ROT_SET | V_ZCLR);
        run1("cb_shift", K_CB_SHIFT, 1'b0, ROT_SET);
        run1("bit", K_BIT, 1'b0, V_ZWE | V_HWE | V_HSET | V_NWE | V_NCLR | V_ALU);
        run1("cpl", K_CPL, 1'b0, V_HWE | V_HSET | V_NWE | V_NSET | V_ALU);
        run1("scf", K_SCF, 1'b1, V_CWE | V_CSET | V_HWE | V_NWE | V_NCLR | V_ALU);
        run1("ccf", K_CCF, 1'b0, V_CWE | V_CCPL | V_HWE | V_NWE | V_NCLR | V_ALU);
        run1("pop_af", K_POP_AF, 1'b0, V_ZWE | V_NWE | V_HWE | V_CWE | V_BUS);
        run1("nop", K_NOP, 1'b0, 22'd0);
        run1("reserved", 4'd13, 1'b1, 22'd0);
        run2("add16", K_ADD16, 1'b1, LO_SET, HI_SET);
        run2("add_sp", K_ADD_SP, 1'b0, LO_SET, HI_SET | V_ZWE | V_ZCLR);
`ifdef SM83_FLAGS_SEQ_DAA_EN
        run2("daa", K_DAA, 1'b0, V_SCWE | V_SCDAA | V_ALU, V_SCSEL | V_ZWE | V_HWE | V_ALU);
`else
        run1("daa_as_nop", K_DAA, 1'b0, 22'd0);
`endif

        // Asynchronous reset in the LO phase of ADD16.
        issue("rst_mid", K_ADD16, 1'b0);
        check("rst_mid_lo", 32'(obs), 32'(LO_SET | V_BUSY));
        #2 reset_n = 1'b0;
        #1 check("rst_mid_async", 32'(obs), 32'(V_RDY));
        #3 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_no_carry", 32'(carry_we), 32'd0);
            check("rst_mid_idle", 32'(obs), 32'(V_RDY));
        end

        // Flush in the first cycle of a two-cycle sequence.
`ifdef SM83_FLAGS_SEQ_DAA_EN
        issue("flush_seq", K_DAA, 1'b0);
        check("flush_seq_c1", 32'(obs), 32'(V_SCWE | V_SCDAA | V_ALU | V_BUSY));
`else
        issue("flush_seq", K_ADD16, 1'b0);
        check("flush_seq_c1", 32'(obs), 32'(LO_SET | V_BUSY));
`endif
        #1 flush = 1'b1;
        #1 check("flush_seq_quiet", 32'(obs), 32'(V_BUSY));
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_seq_idle", 32'(obs), 32'(V_RDY));

        // Flush coinciding with an accept drops the request.
        @(negedge clk);
        op_valid = 1'b1;
        op_kind  = K_ALU8;
        flush    = 1'b1;
        #1 check("flush_acc_ready", 32'(obs), 32'(V_RDY));
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        check("flush_acc_dropped", 32'(obs), 32'(V_RDY));

        // Random stream; the invariant monitor checks every cycle.
        for (int i = 0; i < 30000; i++) begin
            @(posedge clk);
            #1;
            op_valid = ($urandom_range(0, 3) != 0);
            op_kind  = 4'($urandom_range(0, 15));
            op_sub   = 1'($urandom_range(0, 1));
            flush    = ($urandom_range(0, 15) == 0);
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        flush    = 1'b0;
        repeat (3) @(negedge clk);
        check("final_idle", 32'(obs), 32'(V_RDY));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sm83_flags_seq.md
# sm83_flags_seq

Sequencer that drives the control strobes of the SM83 flags register from a single flag-operation request per instruction. Sits between the instruction decoder and the flags register. It accepts one flag-op at a time over a valid/ready handshake, then walks a small FSM that emits the per-cycle write-enable/select strobes, including the two-cycle 16-bit and DAA sequences. It guarantees the flags register's legality rules on every cycle: bus/ALU source exclusive, and primary and secondary carry never written together.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: system clock; all state changes on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `op_valid` in 1: request present.
- `op_ready` out 1: high only in IDLE; transfer when `op_valid && op_ready`.
- `op_kind` in 4: `flag_op_e`: NOP, ALU8, INC_DEC, ADD16, ADD_SP, ROT_A, CB_SHIFT, BIT, DAA, CPL, SCF, CCF, POP_AF.
- `op_sub` in 1: subtract variant (SUB/SBC/CP/DEC); selects `neg_set` instead of `neg_clr`.
- `flush` in 1: synchronous abort of the sequence in flight.
- `busy` out 1: FSM not in IDLE.
- `done` out 1: high during the final strobe cycle of a sequence.
- `alu_hi` out 1: high in the HI phase of 16-bit ops; selects the ALU high byte.
- Flags-register strobes, each out 1: `flags_bus`, `flags_alu`, `zero_we`, `zero_clr`, `half_carry_we`, `half_carry_set`, `half_carry_cpl`, `daa_carry_we`, `neg_we`, `neg_set`, `neg_clr`, `carry_we`, `sec_carry_we`, `sec_carry_sh`, `sec_carry_daa`, `sec_carry_sel`, `carry_set`, `carry_cpl`.

## Operation
- States: IDLE, EXEC, LO, HI, DAA1, DAA2.
- Transitions from IDLE on accept:
  - ADD16 and ADD_SP go to LO.
  - DAA goes to DAA1.
  - All other ops go to EXEC.
- LO always goes to HI. DAA1 always goes to DAA2.
- EXEC, HI and DAA2 return to IDLE.
- Opcode and `op_sub` are latched on accept and held until return to IDLE.
- All strobes are 0 in IDLE. A strobe not listed for a state is 0 in that state.
- EXEC strobes by op:
  - ALU8: zero_we, half_carry_we, daa_carry_we, neg_we, carry_we, flags_alu. neg_set if op_sub, else neg_clr.
  - INC_DEC: the ALU8 set without carry_we.
  - ROT_A: sec_carry_we, sec_carry_sh, sec_carry_sel, zero_we, zero_clr, half_carry_we, half_carry_set, half_carry_cpl, neg_we, neg_clr, flags_alu.
  - CB_SHIFT: the ROT_A set, but zero_we without zero_clr.
  - BIT: zero_we, half_carry_we, half_carry_set, neg_we, neg_clr, flags_alu.
  - CPL: half_carry_we, half_carry_set, neg_we, neg_set, flags_alu.
  - SCF: carry_we, carry_set, half_carry_we, neg_we, neg_clr, flags_alu.
  - CCF: carry_we, carry_cpl, half_carry_we, neg_we, neg_clr, flags_alu.
  - POP_AF: zero_we, neg_we, half_carry_we, carry_we, flags_bus.
  - NOP: all strobes 0; `done` still pulses.
- 16-bit sequence:
  - LO: sec_carry_we, sec_carry_sel, flags_alu. Captures the low-byte carry.
  - HI: alu_hi, sec_carry_sel, half_carry_we, carry_we, neg_we, neg_clr, flags_alu.
  - ADD_SP additionally asserts zero_we and zero_clr in HI.
- DAA sequence:
  - DAA1: sec_carry_we, sec_carry_daa, flags_alu.
  - DAA2: sec_carry_sel, zero_we, half_carry_we, flags_alu.
- Invariants, every cycle:
  - `!(carry_we && sec_carry_we)`.
  - `flags_bus + flags_alu == 1` whenever any `*_we` is high, else both 0.
  - `sec_carry_sh && sec_carry_daa` is never high together.
- `flush`: next state is IDLE and every strobe is forced 0 in the cycle `flush` is high. If `flush` and an accept coincide, the request is dropped (`op_ready` still reads 1).

## Timing
- Reset values: state IDLE, `op_ready`=1, `busy`=0, `done`=0, `alu_hi`=0, all strobes 0.
- Reset mid-sequence: all outputs drop asynchronously. No partial write is issued after reset is released.
- Strobes are registered-state Moore outputs; they appear the cycle after accept.
- Latency is 1 strobe cycle for single-cycle ops and 2 cycles for ADD16, ADD_SP and DAA.
- Throughput: the next accept is possible in the cycle after `done`, so there is one IDLE bubble between ops.
- `op_valid` may drop without `op_ready`; there is no hold requirement.

## Configuration
- `SM83_FLAGS_SEQ_DAA_EN` defined: DAA runs DAA1→DAA2 as above.
- `SM83_FLAGS_SEQ_DAA_EN` undefined:
  - DAA1 and DAA2 are not compiled.
  - An accepted DAA behaves as NOP: one EXEC cycle, no strobes, `done`=1.
  - `sec_carry_daa` is tied 0.

## Structure
- Package `sm83_pkg` holds:
  - `flag_op_e` (4-bit enum).
  - `flags_seq_state_e`.
  - `flags_ctl_t`: packed struct of the 18 strobes plus `alu_hi`.
- Sub-module `sm83_flags_decode`: combinational map from (state, op, op_sub) to `flags_ctl_t`.
- The top level holds the FSM, the latch and flush gating.

## Test plan
- Reset asserted in LO of ADD16 → all strobes 0 immediately. After release, `op_ready`=1 and no carry_we pulse occurs.
- ALU8 with op_sub=1 accepted at cycle 0 → at cycle 1: zero_we, half_carry_we, daa_carry_we, neg_we, neg_set, carry_we, flags_alu, done all 1; cycle 2 IDLE.
- ADD16 → cycle 1: sec_carry_we=1, carry_we=0, alu_hi=0. Cycle 2: carry_we=1, sec_carry_we=0, alu_hi=1, done=1.
- POP_AF → exactly one cycle with flags_bus=1, flags_alu=0, and zero/neg/half_carry/carry_we all 1.
- `flush` asserted in DAA1 → strobes 0 that cycle; the next cycle is IDLE with no DAA2 strobes.
- Random op stream of 10k ops → the three invariants hold every cycle. With the macro undefined, DAA yields done=1 and all strobes 0.
